imem_responder: RTL and testbench

- Instruction-memory responder on the fetch interface: accepts PC fetch requests from the fetch stage and returns the 32-bit instruction word at that address.
- Word-organised storage, one-cycle read latency, and a small response FIFO so fetch back-pressure (decode stall) never drops an instruction.
- Storage is written through a separate program-load port before or between runs.

---
 rtl/imem_responder.sv | 135 +++++++++++++
 tb/tb_imem_responder.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: word-organised storage with a one-cycle read stage
// feeding a small response FIFO, plus a separate program-load write port.
module imem_responder #(
    parameter int unsigned MEM_WORDS  = 256,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_inst,
    output logic [31:0] resp_pc,
    output logic        resp_err,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);
    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        err;
    } resp_t;

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
    endfunction

    logic [31:0]   mem [MEM_WORDS];
    resp_t         fifo_q [FIFO_DEPTH];

    resp_t         rd_q, rd_d;
    logic          rd_valid_q, rd_valid_d;
    resp_t         last_q, last_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] occ_q, occ_d;

    logic          accept, pop, pop_fifo, push_fifo, fifo_empty;
    resp_t         head;

    // occ counts FIFO entries plus the in-flight read, so a full count blocks new
    // requests without looking at resp_ready.
    assign req_ready  = occ_q < CW'(FIFO_DEPTH);
    assign accept     = req_valid && req_ready;
    assign fifo_empty = (cnt_q == '0);

    // With the FIFO empty the in-flight word is presented directly, which is what
    // lets a single slot of occupancy sustain one fetch per cycle.
    assign head       = fifo_empty ? rd_q : fifo_q[rd_ptr_q];
    assign resp_valid = !fifo_empty || rd_valid_q;
    assign pop        = resp_valid && resp_ready;
    assign pop_fifo   = pop && !fifo_empty;
    assign push_fifo  = rd_valid_q && !(pop && fifo_empty);

    assign resp_inst  = resp_valid ? head.inst : last_q.inst;
    assign resp_pc    = resp_valid ? head.pc   : last_q.pc;
    assign resp_err   = resp_valid ? head.err  : last_q.err;

    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        rd_valid_d = accept;
        rd_d       = rd_q;
        last_d     = last_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        occ_d      = occ_q;

        if (accept) begin
            rd_d.pc   = req_addr;
            rd_d.err  = addr_bad(req_addr);
            rd_d.inst = rd_d.err ? NOP_INST : mem[req_addr[AW+1:2]];
        end

        if (push_fifo) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_fifo)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (pop)       last_d   = head;

        unique case ({push_fifo, pop_fifo})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        unique case ({accept, pop})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
            last_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            occ_q      <= '0;
        end else begin
            rd_q       <= rd_d;
            rd_valid_q <= rd_valid_d;
            last_q     <= last_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            occ_q      <= occ_d;
        end
    end

    // NOTE: storage arrays carry no reset; validity is tracked by the pointers and
    // counters, and leaving them unreset keeps them mappable to RAM.
    always_ff @(posedge clk) begin
        if (push_fifo) fifo_q[wr_ptr_q] <= rd_q;
    end

    // A fetch of the word written on the same edge samples the pre-write value.
    always_ff @(posedge clk) begin
        if (ld_en && !rst && !addr_bad(ld_addr)) mem[ld_addr[AW+1:2]] <= ld_data;
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed and scoreboard-driven bench for imem_responder (MEM_WORDS=256, FIFO_DEPTH=2).
module tb_imem_responder;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_inst, resp_pc;
    logic        resp_err;
    logic        ld_en;
    logic [31:0] ld_addr, ld_data;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    imem_responder #(.MEM_WORDS(256), .FIFO_DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_inst(resp_inst), .resp_pc(resp_pc), .resp_err(resp_err),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({resp_valid, resp_inst, resp_pc, resp_err, req_ready} !== {1'b0, 32'h0, 32'h0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_state: got v=%b inst=%h pc=%h err=%b rdy=%b, want v=0 inst=0 pc=0 err=0 rdy=1",
                     resp_valid, resp_inst, resp_pc, resp_err, req_ready);
        end
    endtask

    task automatic test_basic();
        load(32'h0, 32'h0050_0093);
        load(32'h4, 32'h00A0_0113);
        load(32'h8, 32'h1111_1111);
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_addr   = 32'h0;
        #1;
        total++;
        if (resp_valid !== 1'b0) begin
            bad++; $display("FAIL basic_pre_accept: resp_valid=%b want 0", resp_valid);
        end
        tick();
        total++;
        if ({resp_valid, resp_inst, resp_pc, resp_err} !== {1'b1, 32'h0050_0093, 32'h0, 1'b0}) begin
            bad++; $display("FAIL basic_first: got %b %h %h %b want 1 00500093 00000000 0", resp_valid, resp_inst, resp_pc, resp_err);
        end
        req_addr = 32'h4;
        tick();
        total++;
        if ({resp_valid, resp_inst, resp_pc, resp_err} !== {1'b1, 32'h00A0_0113, 32'h4, 1'b0}) begin
            bad++; $display("FAIL basic_second: got %b %h %h %b want 1 00a00113 00000004 0", resp_valid, resp_inst, resp_pc, resp_err);
        end
        req_valid = 1'b0;
        tick();
        total++;
        if ({resp_valid, resp_inst, resp_pc, resp_err} !== {1'b0, 32'h00A0_0113, 32'h4, 1'b0}) begin
            bad++; $display("FAIL basic_hold_last: got %b %h %h %b want 0 00a00113 00000004 0", resp_valid, resp_inst, resp_pc, resp_err);
        end
    endtask

    task automatic test_backpressure();
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 32'h0;
        tick();
        req_addr = 32'h4;
        tick();
        req_addr = 32'h8;
        total++;
        if ({req_ready, resp_valid, resp_inst, resp_pc} !== {1'b0, 1'b1, 32'h0050_0093, 32'h0}) begin
            bad++; $display("FAIL bp_full: got rdy=%b v=%b inst=%h pc=%h want rdy=0 v=1 00500093 0", req_ready, resp_valid, resp_inst, resp_pc);
        end
        tick();
        total++;
        if ({req_ready, resp_valid, resp_inst, resp_pc} !== {1'b0, 1'b1, 32'h0050_0093, 32'h0}) begin
            bad++; $display("FAIL bp_stall_stable: got rdy=%b v=%b inst=%h pc=%h want rdy=0 v=1 00500093 0", req_ready, resp_valid, resp_inst, resp_pc);
        end
        resp_ready = 1'b1;
        tick();
        total++;
        if ({req_ready, resp_valid, resp_inst, resp_pc} !== {1'b1, 1'b1, 32'h00A0_0113, 32'h4}) begin
            bad++; $display("FAIL bp_first_pop: got rdy=%b v=%b inst=%h pc=%h want rdy=1 v=1 00a00113 4", req_ready, resp_valid, resp_inst, resp_pc);
        end
        tick();
        req_valid = 1'b0;
        total++;
        if ({resp_valid, resp_inst, resp_pc} !== {1'b1, 32'h1111_1111, 32'h8}) begin
            bad++; $display("FAIL bp_third: got v=%b inst=%h pc=%h want v=1 11111111 8", resp_valid, resp_inst, resp_pc);
        end
        tick();
        total++;
        if (resp_valid !== 1'b0) begin
            bad++; $display("FAIL bp_drained: resp_valid=%b want 0", resp_valid);
        end
        tick();
        total++;
        if (resp_valid !== 1'b0) begin
            bad++; $display("FAIL bp_no_duplicate: resp_valid=%b want 0", resp_valid);
        end
    endtask

    task automatic test_errors();
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_addr   = 32'h6;
        tick();
        total++;
        if ({resp_valid, resp_inst, resp_pc, resp_err} !== {1'b1, NOP, 32'h6, 1'b1}) begin
            bad++; $display("FAIL err_misaligned: got %b %h %h %b want 1 00000013 00000006 1", resp_valid, resp_inst, resp_pc, resp_err);
        end
        req_addr = 32'h400;
        tick();
        total++;
        if ({resp_valid, resp_inst, resp_pc, resp_err} !== {1'b1, NOP, 32'h400, 1'b1}) begin
            bad++; $display("FAIL err_range: got %b %h %h %b want 1 00000013 00000400 1", resp_valid, resp_inst, resp_pc, resp_err);
        end
        req_addr = 32'h0;
        tick();
        total++;
        if ({resp_valid, resp_inst, resp_pc, resp_err} !== {1'b1, 32'h0050_0093, 32'h0, 1'b0}) begin
            bad++; $display("FAIL err_clears: got %b %h %h %b want 1 00500093 0 0", resp_valid, resp_inst, resp_pc, resp_err);
        end
        req_valid = 1'b0;
        tick();
    endtask

    task automatic test_read_before_write();
        ld_en     = 1'b1;
        ld_addr   = 32'h8;
        ld_data   = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        req_addr  = 32'h8;
        tick();
        ld_en = 1'b0;
        total++;
        if ({resp_valid, resp_inst, resp_pc} !== {1'b1, 32'h1111_1111, 32'h8}) begin
            bad++; $display("FAIL rbw_old: got v=%b inst=%h pc=%h want 1 11111111 8", resp_valid, resp_inst, resp_pc);
        end
        tick();
        total++;
        if ({resp_valid, resp_inst, resp_pc} !== {1'b1, 32'hDEAD_BEEF, 32'h8}) begin
            bad++; $display("FAIL rbw_new: got v=%b inst=%h pc=%h want 1 deadbeef 8", resp_valid, resp_inst, resp_pc);
        end
        req_valid = 1'b0;
        tick();
    endtask

    task automatic test_load_drop();
        load(32'h9,   32'h1234_5678);
        load(32'h408, 32'h8765_4321);
        load(32'hC,   32'hCAFE_000C);
        req_valid = 1'b1;
        req_addr  = 32'h8;
        tick();
        total++;
        if (resp_inst !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL load_drop: got inst=%h want deadbeef", resp_inst);
        end
        req_addr = 32'hC;
        tick();
        total++;
        if (resp_inst !== 32'hCAFE_000C) begin
            bad++; $display("FAIL load_good: got inst=%h want cafe000c", resp_inst);
        end
        req_valid = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        bit stale = 1'b0;
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 32'h0;
        tick();
        req_addr = 32'h4;
        tick();
        req_valid = 1'b0;
        total++;
        if ({resp_valid, req_ready} !== 2'b10) begin
            bad++; $display("FAIL ar_pending: got v=%b rdy=%b want v=1 rdy=0", resp_valid, req_ready);
        end
        #3;
        rst = 1'b1;
        #1;
        total++;
        if ({resp_valid, resp_inst, resp_pc, resp_err} !== {1'b0, 32'h0, 32'h0, 1'b0}) begin
            bad++; $display("FAIL ar_immediate: got %b %h %h %b want all 0", resp_valid, resp_inst, resp_pc, resp_err);
        end
        ld_en   = 1'b1;
        ld_addr = 32'h0;
        ld_data = 32'hBAD0_BAD0;
        @(posedge clk);
        @(posedge clk);
        #5;
        ld_en = 1'b0;
        rst   = 1'b0;
        tick();
        total++;
        if ({req_ready, resp_valid} !== 2'b10) begin
            bad++; $display("FAIL ar_release: got rdy=%b v=%b want rdy=1 v=0", req_ready, resp_valid);
        end
        resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (resp_valid !== 1'b0) stale = 1'b1;
        end
        total++;
        if (stale) begin
            bad++; $display("FAIL ar_stale: resp_valid seen 1 after reset, want 0");
        end
        req_valid = 1'b1;
        req_addr  = 32'h0;
        tick();
        total++;
        if ({resp_valid, resp_inst, resp_pc} !== {1'b1, 32'h0050_0093, 32'h0}) begin
            bad++; $display("FAIL ar_mem_kept0: got v=%b inst=%h pc=%h want 1 00500093 0", resp_valid, resp_inst, resp_pc);
        end
        req_addr = 32'h4;
        tick();
        total++;
        if ({resp_valid, resp_inst, resp_pc} !== {1'b1, 32'h00A0_0113, 32'h4}) begin
            bad++; $display("FAIL ar_mem_kept4: got v=%b inst=%h pc=%h want 1 00a00113 4", resp_valid, resp_inst, resp_pc);
        end
        req_valid = 1'b0;
        tick();
    endtask

    task automatic test_random_stream();
        logic [31:0] addr_tab [7] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h6, 32'h400, 32'h1};
        logic [31:0] inst_tab [7] = '{32'h0050_0093, 32'h00A0_0113, 32'hDEAD_BEEF, 32'hCAFE_000C, NOP, NOP, NOP};
        logic        err_tab  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_t q[$];
        exp_t e;
        int   accepted = 0;
        int   cyc      = 0;
        int   idx;
        while ((accepted < 1000 || q.size() != 0) && cyc < 20000) begin
            idx        = int'($urandom_range(0, 6));
            req_valid  = (accepted < 1000) && ($urandom_range(0, 3) != 0);
            req_addr   = addr_tab[idx];
            resp_ready = (accepted >= 1000) || ($urandom_range(0, 2) != 0);
            #1;
            total++;
            if (req_ready !== (q.size() < DEPTH)) begin
                bad++; $display("FAIL rnd_ready cyc=%0d: got %b want %b (occ %0d)", cyc, req_ready, q.size() < DEPTH, q.size());
            end
            total++;
            if (resp_valid !== (q.size() > 0)) begin
                bad++; $display("FAIL rnd_valid cyc=%0d: got %b want %b", cyc, resp_valid, q.size() > 0);
            end
            if (resp_valid && resp_ready && q.size() > 0) begin
                e = q.pop_front();
                total++;
                if ({resp_inst, resp_pc, resp_err} !== e) begin
                    bad++; $display("FAIL rnd_data cyc=%0d: got %h %h %b want %h %h %b",
                                    cyc, resp_inst, resp_pc, resp_err, e.inst, e.pc, e.err);
                end
            end
            if (req_valid && req_ready) begin
                q.push_back('{inst: inst_tab[idx], pc: addr_tab[idx], err: err_tab[idx]});
                accepted++;
            end
            tick();
            cyc++;
        end
        req_valid = 1'b0;
        total++;
        if (accepted != 1000 || q.size() != 0) begin
            bad++; $display("FAIL rnd_complete: accepted=%0d outstanding=%0d want 1000 and 0", accepted, q.size());
        end
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = '0;
        resp_ready = 1'b0;
        ld_en      = 1'b0;
        ld_addr    = '0;
        ld_data    = '0;
        repeat (2) @(posedge clk);
        #5;
        rst = 1'b0;
        tick();

        test_reset();
        test_basic();
        test_backpressure();
        test_errors();
        test_read_before_write();
        test_load_drop();
        test_async_reset();
        test_random_stream();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
